attitude_pd_ctrl: RTL and testbench



---
 rtl/pd_ctrl_pkg.sv | 41 ++++
 rtl/err_hist_q.sv | 29 ++
 rtl/attitude_pd_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_attitude_pd_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_ctrl_pkg.sv
// Shared types, default constants and saturation helpers for the attitude PD controller.
package pd_ctrl_pkg;

    typedef enum logic [2:0] {StIdle, StPtch, StRoll, StYaw, StMix} state_e;

    localparam int unsigned DQueueDepthDef = 12;
    localparam int unsigned DCoeffDef      = 9;
    localparam logic [12:0] MinRunSpeedDef = 13'h02C0;

    function automatic logic signed [9:0] sat10(input logic signed [16:0] x);
        if (x > 17'sd511) begin
            return 10'h1FF;
        end else if (x < -17'sd512) begin
            return 10'h200;
        end else begin
            return x[9:0];
        end
    endfunction

    function automatic logic signed [6:0] sat7(input logic signed [10:0] x);
        if (x > 11'sd63) begin
            return 7'h3F;
        end else if (x < -11'sd64) begin
            return 7'h40;
        end else begin
            return x[6:0];
        end
    endfunction

    // Out of 0..2047 exactly when either of the two top bits is set.
    function automatic logic [10:0] clamp11(input logic signed [12:0] x);
        if (x[12]) begin
            return 11'd0;
        end else if (x[11]) begin
            return 11'h7FF;
        end else begin
            return x[10:0];
        end
    endfunction

endpackage

// File: rtl/err_hist_q.sv
// Fixed-depth shift queue of past saturated errors; oldest entry is visible combinationally.
module err_hist_q #(
    parameter int unsigned Depth = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic signed [9:0] din_i,
    output logic signed [9:0] oldest_o
);

    logic signed [9:0] q_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                q_q[i] <= '0;
            end
        end else if (push_i) begin
            q_q[0] <= din_i;
            for (int i = 1; i < int'(Depth); i++) begin
                q_q[i] <= q_q[i-1];
            end
        end
    end

    assign oldest_o = q_q[Depth-1];

endmodule

// File: rtl/attitude_pd_ctrl.sv
// Time-multiplexed per-axis PD controller mixing attitude corrections into four motor speeds.
// Define MTR_SAT_STS_EN to add the sticky per-motor saturation status (clr_sat / sat_sts).
module attitude_pd_ctrl
    import pd_ctrl_pkg::*;
#(
    parameter int unsigned D_QUEUE_DEPTH = DQueueDepthDef,
    parameter int unsigned D_COEFF       = DCoeffDef,
    parameter logic [12:0] MIN_RUN_SPEED = MinRunSpeedDef
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vld,
    input  logic               cal_done,
    input  logic signed [15:0] ptch,
    input  logic signed [15:0] roll,
    input  logic signed [15:0] yaw,
    input  logic signed [15:0] d_ptch,
    input  logic signed [15:0] d_roll,
    input  logic signed [15:0] d_yaw,
    input  logic        [8:0]  thrst,
`ifdef MTR_SAT_STS_EN
    input  logic               clr_sat,
    output logic        [3:0]  sat_sts,
`endif
    output logic        [10:0] frnt_spd,
    output logic        [10:0] bck_spd,
    output logic        [10:0] lft_spd,
    output logic        [10:0] rght_spd,
    output logic               mtr_vld,
    output logic               busy
);

    localparam logic [11:0] DCoef12 = 12'(D_COEFF);

    state_e             state_q, state_d;
    logic signed [15:0] meas_q [3];
    logic signed [15:0] des_q  [3];
    logic        [8:0]  thrst_q;
    logic signed [12:0] sum_q  [3];
    logic        [10:0] mix_q  [4];
    logic        [10:0] spd_q  [4];
    logic               mix_pend_q, mtr_vld_q, busy_q;

    logic               accept, axis_act;
    logic        [1:0]  ax;
    logic signed [16:0] err;
    logic signed [9:0]  err_sat, pterm;
    logic signed [12:0] prod;
    logic signed [9:0]  oldest [3];
    logic signed [10:0] diff11;
    logic signed [6:0]  diff7;
    logic signed [11:0] dterm;
    logic signed [12:0] axis_sum, base;
    logic signed [12:0] raw [4];

    // busy_q lags the FSM by one cycle, so it also blocks a strobe on the cycle after MIX.
    assign accept = (state_q == StIdle) && !busy_q && vld && cal_done;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StPtch;
            StPtch:  state_d = StRoll;
            StRoll:  state_d = StYaw;
            StYaw:   state_d = StMix;
            StMix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ax       = 2'd0;
        axis_act = 1'b0;
        unique case (state_q)
            StPtch: begin ax = 2'd0; axis_act = 1'b1; end
            StRoll: begin ax = 2'd1; axis_act = 1'b1; end
            StYaw:  begin ax = 2'd2; axis_act = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        err      = {meas_q[ax][15], meas_q[ax]} - {des_q[ax][15], des_q[ax]};
        err_sat  = sat10(err);
        prod     = {{3{err_sat[9]}}, err_sat} * 13'sd5;
        pterm    = 10'(prod >>> 3);
        diff11   = {err_sat[9], err_sat} - {oldest[ax][9], oldest[ax]};
        diff7    = sat7(diff11);
        dterm    = {{5{diff7[6]}}, diff7} * DCoef12;
        axis_sum = {{3{pterm[9]}}, pterm} + {dterm[11], dterm};
    end

    for (genvar g = 0; g < 3; g++) begin : g_hist
        err_hist_q #(
            .Depth(D_QUEUE_DEPTH)
        ) u_hist (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .push_i  (axis_act && (ax == 2'(g))),
            .din_i   (err_sat),
            .oldest_o(oldest[g])
        );
    end

    always_comb begin
        base   = $signed({4'b0000, thrst_q}) + $signed(MIN_RUN_SPEED);
        raw[0] = base + sum_q[0] - sum_q[2];
        raw[1] = base - sum_q[0] - sum_q[2];
        raw[2] = base + sum_q[1] + sum_q[2];
        raw[3] = base - sum_q[1] + sum_q[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            thrst_q    <= '0;
            mix_pend_q <= 1'b0;
            mtr_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                meas_q[i] <= '0;
                des_q[i]  <= '0;
                sum_q[i]  <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                mix_q[i] <= '0;
                spd_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            busy_q  <= (state_q != StIdle);
            if (accept) begin
                meas_q[0] <= ptch;
                meas_q[1] <= roll;
                meas_q[2] <= yaw;
                des_q[0]  <= d_ptch;
                des_q[1]  <= d_roll;
                des_q[2]  <= d_yaw;
                thrst_q   <= thrst;
            end
            if (axis_act) sum_q[ax] <= axis_sum;
            mix_pend_q <= (state_q == StMix) && cal_done;
            mtr_vld_q  <= mix_pend_q && cal_done;
            for (int i = 0; i < 4; i++) begin
                if (state_q == StMix) mix_q[i] <= clamp11(raw[i]);
                if (!cal_done) begin
                    spd_q[i] <= '0;
                end else if (mix_pend_q) begin
                    spd_q[i] <= mix_q[i];
                end
            end
        end
    end

`ifdef MTR_SAT_STS_EN
    logic [3:0] sat_q, sat_d, sat_set;

    always_comb begin
        sat_set = {raw[0][12] | raw[0][11], raw[1][12] | raw[1][11],
                   raw[2][12] | raw[2][11], raw[3][12] | raw[3][11]}
                  & {4{(state_q == StMix) && cal_done}};
        sat_d   = sat_set | (sat_q & ~{4{clr_sat}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= '0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_sts = sat_q;
`endif

    assign frnt_spd = spd_q[0];
    assign bck_spd  = spd_q[1];
    assign lft_spd  = spd_q[2];
    assign rght_spd = spd_q[3];
    assign mtr_vld  = mtr_vld_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_attitude_pd_ctrl.sv
// Self-checking bench for attitude_pd_ctrl: directed vectors plus randomized samples vs a model.
module tb_attitude_pd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic        cal_done = 1'b1;
    logic [15:0] ptch = '0, roll = '0, yaw = '0, d_ptch = '0, d_roll = '0, d_yaw = '0;
    logic [8:0]  thrst = '0;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic        mtr_vld, busy;
`ifdef MTR_SAT_STS_EN
    logic        clr_sat = 1'b0;
    logic [3:0]  sat_sts;
`endif

    int checks = 0;
    int errors = 0;

    // Results of the most recent do_sample call.
    int          got_lat, got_nv;
    logic [9:0]  got_busy;
    logic [10:0] got_spd [4];
    int          exp_spd [4];
    string       nm [4] = '{"frnt", "bck", "lft", "rght"};

    // Reference error histories: front is the oldest saturated error.
    int qp[$], qr[$], qy[$];

    attitude_pd_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld     (vld),
        .cal_done(cal_done),
        .ptch    (ptch),
        .roll    (roll),
        .yaw     (yaw),
        .d_ptch  (d_ptch),
        .d_roll  (d_roll),
        .d_yaw   (d_yaw),
        .thrst   (thrst),
`ifdef MTR_SAT_STS_EN
        .clr_sat (clr_sat),
        .sat_sts (sat_sts),
`endif
        .frnt_spd(frnt_spd),
        .bck_spd (bck_spd),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .mtr_vld (mtr_vld),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int floor_div8(int v);
        return (v >= 0) ? v / 8 : -((-v + 7) / 8);
    endfunction

    function automatic int axis_val(int meas, int des, int oldest, output int esat);
        esat = clampi(meas - des, -512, 511);
        return floor_div8(esat * 5) + clampi(esat - oldest, -64, 63) * 9;
    endfunction

    task automatic model_reset();
        qp.delete(); qr.delete(); qy.delete();
        repeat (12) begin
            qp.push_back(0); qr.push_back(0); qy.push_back(0);
        end
    endtask

    task automatic model_step(input logic [15:0] p, r, y, dp, dr, dy, input logic [8:0] t);
        int pv, rv, yv, s, base;
        pv = axis_val(int'($signed(p)), int'($signed(dp)), qp[0], s);
        void'(qp.pop_front()); qp.push_back(s);
        rv = axis_val(int'($signed(r)), int'($signed(dr)), qr[0], s);
        void'(qr.pop_front()); qr.push_back(s);
        yv = axis_val(int'($signed(y)), int'($signed(dy)), qy[0], s);
        void'(qy.pop_front()); qy.push_back(s);
        base = int'(t) + 704;
        exp_spd[0] = clampi(base + pv - yv, 0, 2047);
        exp_spd[1] = clampi(base - pv - yv, 0, 2047);
        exp_spd[2] = clampi(base + rv + yv, 0, 2047);
        exp_spd[3] = clampi(base - rv + yv, 0, 2047);
    endtask

    // Strobe one sample at edge k, then observe edges k+1..k+10.
    task automatic do_sample(input logic [15:0] p, r, y, dp, dr, dy, input logic [8:0] t);
        ptch = p; roll = r; yaw = y; d_ptch = dp; d_roll = dr; d_yaw = dy; thrst = t;
        vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        got_lat = -1; got_nv = 0; got_busy = '0;
        for (int i = 0; i < 4; i++) got_spd[i] = 'x;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            got_busy[c-1] = busy;
            if (mtr_vld === 1'b1) begin
                got_nv++;
                if (got_lat < 0) begin
                    got_lat = c;
                    got_spd[0] = frnt_spd; got_spd[1] = bck_spd;
                    got_spd[2] = lft_spd;  got_spd[3] = rght_spd;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
    endtask

    function automatic logic [15:0] rnd16();
        int v;
        if ($urandom_range(3) == 0) return 16'($urandom);
        v = int'($urandom_range(1400)) - 700;
        return v[15:0];
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== 44'd0) begin
            errors++;
            $display("FAIL reset_speeds: got %h expected 0", {frnt_spd, bck_spd, lft_spd, rght_spd});
        end
        checks++;
        if (mtr_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got vld=%b busy=%b expected 0 0", mtr_vld, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mtr_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got vld=%b busy=%b expected 0 0", mtr_vld, busy);
        end
`ifdef MTR_SAT_STS_EN
        checks++;
        if (sat_sts !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sat_sts: got %b expected 0000", sat_sts);
        end
`endif
        model_reset();
    endtask

    task automatic test_directed();
        logic [15:0] vp [3] = '{16'h0040, 16'h7FFF, 16'hFDA8};
        logic [15:0] vd [3] = '{16'h0000, 16'h8000, 16'h0000};
        logic [8:0]  vt [3] = '{9'd0, 9'd511, 9'd0};
        int          ve [3][4] = '{'{1311, 97, 704, 704}, '{2047, 329, 1215, 1215},
                                   '{0, 1600, 704, 704}};
        for (int v = 0; v < 3; v++) begin
            do_sample(vp[v], '0, '0, vd[v], '0, '0, vt[v]);
            model_step(vp[v], '0, '0, vd[v], '0, '0, vt[v]);
            checks++;
            if (got_lat != 5 || got_nv != 1) begin
                errors++;
                $display("FAIL dir%0d_latency: got lat=%0d n=%0d expected lat=5 n=1",
                         v, got_lat, got_nv);
            end
            checks++;
            if (got_busy !== 10'h00F) begin
                errors++;
                $display("FAIL dir%0d_busy: got %b expected 0000001111", v, got_busy);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_spd[i] !== 11'(ve[v][i])) begin
                    errors++;
                    $display("FAIL dir%0d_%s: got %0d expected %0d", v, nm[i], got_spd[i],
                             ve[v][i]);
                end
            end
`ifdef MTR_SAT_STS_EN
            checks++;
            if (sat_sts !== ((v == 0) ? 4'b0000 : 4'b1000)) begin
                errors++;
                $display("FAIL dir%0d_sat_sts: got %b expected %b", v, sat_sts,
                         (v == 0) ? 4'b0000 : 4'b1000);
            end
            clr_sat = 1'b1;
            @(posedge clk); #1;
            clr_sat = 1'b0;
            checks++;
            if (sat_sts !== 4'b0000) begin
                errors++;
                $display("FAIL dir%0d_sat_clr: got %b expected 0000", v, sat_sts);
            end
`endif
        end
    endtask

    task automatic test_d_queue();
        do_reset();
        for (int s = 1; s <= 13; s++) begin
            do_sample(16'h0040, '0, '0, '0, '0, '0, '0);
            model_step(16'h0040, '0, '0, '0, '0, '0, '0);
            checks++;
            if (got_nv != 1 || got_spd[0] !== ((s <= 12) ? 11'd1311 : 11'd744)) begin
                errors++;
                $display("FAIL dq_sample%0d_frnt: got %0d (n=%0d) expected %0d", s, got_spd[0],
                         got_nv, (s <= 12) ? 1311 : 744);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p = rnd16(), r = rnd16(), y = rnd16();
        logic [8:0]  t = 9'($urandom);
        int lat = -1, nv = 0;
        model_step(p, r, y, '0, '0, '0, t);
        ptch = p; roll = r; yaw = y; d_ptch = '0; d_roll = '0; d_yaw = '0; thrst = t;
        vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        @(posedge clk); #1;
        ptch = rnd16(); roll = rnd16(); thrst = 9'($urandom);
        vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        for (int c = 3; c <= 12; c++) begin
            @(posedge clk); #1;
            if (mtr_vld === 1'b1) begin
                nv++;
                if (lat < 0) begin
                    lat = c;
                    got_spd[0] = frnt_spd; got_spd[1] = bck_spd;
                    got_spd[2] = lft_spd;  got_spd[3] = rght_spd;
                end
            end
        end
        checks++;
        if (nv != 1 || lat != 5) begin
            errors++;
            $display("FAIL b2b_strobe: got n=%0d lat=%0d expected n=1 lat=5", nv, lat);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_spd[i] !== 11'(exp_spd[i])) begin
                errors++;
                $display("FAIL b2b_%s: got %0d expected %0d", nm[i], got_spd[i], exp_spd[i]);
            end
        end
    endtask

    task automatic test_cal_done();
        int nv = 0;
        do_sample(16'h0100, 16'hFF00, 16'h0020, '0, '0, '0, 9'd300);
        model_step(16'h0100, 16'hFF00, 16'h0020, '0, '0, '0, 9'd300);
        checks++;
        if (got_spd[2] !== 11'(exp_spd[2])) begin
            errors++;
            $display("FAIL cal_pre_lft: got %0d expected %0d", got_spd[2], exp_spd[2]);
        end
        cal_done = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== 44'd0) begin
            errors++;
            $display("FAIL cal_force_zero: got %h expected 0", {frnt_spd, bck_spd, lft_spd,
                     rght_spd});
        end
        do_sample(rnd16(), rnd16(), rnd16(), '0, '0, '0, 9'd100);
        checks++;
        if (got_nv != 0 || got_busy !== 10'h000) begin
            errors++;
            $display("FAIL cal_ignored: got n=%0d busy=%b expected n=0 busy=0", got_nv, got_busy);
        end
        cal_done = 1'b1;
        ptch = 16'h0200; roll = 16'h0010; yaw = 16'hFFF0; thrst = 9'd50;
        vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        @(posedge clk); #1;
        cal_done = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            @(posedge clk); #1;
            if (mtr_vld === 1'b1) nv++;
        end
        model_step(16'h0200, 16'h0010, 16'hFFF0, '0, '0, '0, 9'd50);
        checks++;
        if (nv != 0 || {frnt_spd, bck_spd, lft_spd, rght_spd} !== 44'd0) begin
            errors++;
            $display("FAIL cal_inflight: got n=%0d spd=%h expected n=0 spd=0", nv,
                     {frnt_spd, bck_spd, lft_spd, rght_spd});
        end
        cal_done = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] p, r, y, dp, dr, dy;
        logic [8:0]  t;
        for (int n = 0; n < 30; n++) begin
            p = rnd16(); r = rnd16(); y = rnd16();
            dp = rnd16(); dr = rnd16(); dy = rnd16();
            t = 9'($urandom);
            do_sample(p, r, y, dp, dr, dy, t);
            model_step(p, r, y, dp, dr, dy, t);
            checks++;
            if (got_lat != 5 || got_nv != 1) begin
                errors++;
                $display("FAIL rnd%0d_latency: got lat=%0d n=%0d expected lat=5 n=1", n,
                         got_lat, got_nv);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_spd[i] !== 11'(exp_spd[i])) begin
                    errors++;
                    $display("FAIL rnd%0d_%s: got %0d expected %0d", n, nm[i], got_spd[i],
                             exp_spd[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        do_sample(16'h0080, '0, '0, '0, '0, '0, 9'd200);
        model_step(16'h0080, '0, '0, '0, '0, '0, 9'd200);
        ptch = 16'h0300; thrst = 9'd100;
        vld = 1'b1;
        @(posedge clk); #1;
        vld = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== 44'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got spd=%h busy=%b expected 0 0",
                     {frnt_spd, bck_spd, lft_spd, rght_spd}, busy);
        end
        repeat (4) begin
            @(posedge clk); #1;
            if (mtr_vld !== 1'b0) nv++;
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL midrst_no_vld: got %0d strobes expected 0", nv);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        do_sample(16'h0040, '0, '0, '0, '0, '0, '0);
        model_step(16'h0040, '0, '0, '0, '0, '0, '0);
        checks++;
        if (got_lat != 5 || got_spd[0] !== 11'd1311 || got_spd[1] !== 11'd97) begin
            errors++;
            $display("FAIL midrst_first_sample: got lat=%0d frnt=%0d bck=%0d expected 5 1311 97",
                     got_lat, got_spd[0], got_spd[1]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_d_queue();
        test_back_to_back();
        test_cal_done();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
